// File: rtl/atoi_ctl_if.sv
// Bus bundle between the requesters/memory/atoi datapath and the atoi_ctl sequencer.
interface atoi_ctl_if #(
  parameter int unsigned DSZ = 32,
  parameter int unsigned ASZ = 17
);
  // requester side
  logic           req0;
  logic [ASZ-1:0] a0;
  logic           hex0;
  logic           req1;
  logic [ASZ-1:0] a1;
  logic           hex1;
  logic           gnt0;
  logic           gnt1;
  logic           done0;
  logic           done1;
  logic           err;
  logic [DSZ-1:0] vo;
  // byte memory read port
  logic [ASZ-1:0] ma;
  logic [7:0]     mdi;
  // atoi datapath
  logic           atoi_en;
  logic           atoi_hex;
  logic [7:0]     atoi_ch;
  logic           atoi_bsy;
  logic           atoi_af;
  logic [DSZ-1:0] atoi_vo;

  // controller view
  modport slave (
    input  req0, a0, hex0, req1, a1, hex1, mdi, atoi_bsy, atoi_af, atoi_vo,
    output gnt0, gnt1, done0, done1, err, vo, ma, atoi_en, atoi_hex, atoi_ch
  );

  // environment view (requesters, memory, atoi)
  modport master (
    output req0, a0, hex0, req1, a1, hex1, mdi, atoi_bsy, atoi_af, atoi_vo,
    input  gnt0, gnt1, done0, done1, err, vo, ma, atoi_en, atoi_hex, atoi_ch
  );
endinterface

// File: rtl/atoi_ctl.sv
// Round-robin arbiter and sequencer in front of the shared atoi conversion datapath.
module atoi_ctl #(
  parameter int unsigned DSZ    = 32,
  parameter int unsigned ASZ    = 17,
  parameter int unsigned MAXLEN = 16
) (
  input logic       clk,
  input logic       rst,
  atoi_ctl_if.slave bus
);

  localparam int unsigned LW = (MAXLEN < 1) ? 1 : $clog2(MAXLEN + 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    CHK,
    RUN,
    FIN
  } state_t;

  state_t        st;
  logic          own;      // 0 = requester 0 owns the datapath, 1 = requester 1
  logic          rr_last;  // requester that completed last; reset favours requester 0
  logic [LW-1:0] len;      // address advances in the current conversion
  logic [1:0]    run_cnt;  // saturating RUN cycle count for the bsy blanking window
  logic          own_req;
  logic          pick0;
  logic          pick1;

  // The atoi character input is the memory read data itself.
  assign bus.atoi_ch = bus.mdi;

  // Request line of the current owner, used for abort detection.
  assign own_req = own ? bus.req1 : bus.req0;

  // Arbitration: a lone request wins; on contention the one not served last wins.
  assign pick0 = bus.req0 && (!bus.req1 || rr_last);
  assign pick1 = bus.req1 && !pick0;

  // Sequencer FSM with registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st           <= IDLE;
      own          <= 1'b0;
      rr_last      <= 1'b1;
      len          <= '0;
      run_cnt      <= '0;
      bus.gnt0     <= 1'b0;
      bus.gnt1     <= 1'b0;
      bus.done0    <= 1'b0;
      bus.done1    <= 1'b0;
      bus.err      <= 1'b0;
      bus.vo       <= DSZ'(0);
      bus.ma       <= ASZ'(0);
      bus.atoi_en  <= 1'b0;
      bus.atoi_hex <= 1'b0;
    end else begin
      bus.done0 <= 1'b0;
      bus.done1 <= 1'b0;
      case (st)
        IDLE: begin
          if (pick0) begin
            own          <= 1'b0;
            bus.ma       <= bus.a0;
            bus.atoi_hex <= bus.hex0;
            bus.gnt0     <= 1'b1;
            len          <= '0;
            st           <= LOAD;
          end else if (pick1) begin
            own          <= 1'b1;
            bus.ma       <= bus.a1;
            bus.atoi_hex <= bus.hex1;
            bus.gnt1     <= 1'b1;
            len          <= '0;
            st           <= LOAD;
          end
        end

        LOAD: begin
          if (!own_req) begin
            bus.gnt0 <= 1'b0;
            bus.gnt1 <= 1'b0;
            st       <= IDLE;
          end else begin
            st <= CHK;
          end
        end

        CHK: begin
          if (!own_req) begin
            bus.gnt0 <= 1'b0;
            bus.gnt1 <= 1'b0;
            st       <= IDLE;
          end else if (bus.mdi == 8'h00) begin
            // empty token: report error without waking atoi
            bus.err   <= 1'b1;
            bus.vo    <= DSZ'(0);
            bus.done0 <= !own;
            bus.done1 <= own;
            st        <= FIN;
          end else begin
            bus.atoi_en <= 1'b1;
            run_cnt     <= '0;
            st          <= RUN;
          end
        end

        RUN: begin
          if (!own_req) begin
            bus.atoi_en <= 1'b0;
            bus.gnt0    <= 1'b0;
            bus.gnt1    <= 1'b0;
            st          <= IDLE;
          end else if ((run_cnt == 2'd2) && !bus.atoi_bsy) begin
            bus.vo    <= bus.atoi_vo;
            bus.err   <= 1'b0;
            bus.done0 <= !own;
            bus.done1 <= own;
            st        <= FIN;
          end else if (len == LW'(MAXLEN)) begin
            // token too long: give up with an error
            bus.vo    <= DSZ'(0);
            bus.err   <= 1'b1;
            bus.done0 <= !own;
            bus.done1 <= own;
            st        <= FIN;
          end else begin
            if (bus.atoi_af) begin
              bus.ma <= bus.ma + ASZ'(1);
              len    <= len + LW'(1);
            end
            if (run_cnt != 2'd2) begin
              run_cnt <= run_cnt + 2'd1;
            end
          end
        end

        FIN: begin
          bus.atoi_en <= 1'b0;
          bus.gnt0    <= 1'b0;
          bus.gnt1    <= 1'b0;
          rr_last     <= own;
          st          <= IDLE;
        end

        default: begin
          bus.atoi_en <= 1'b0;
          bus.gnt0    <= 1'b0;
          bus.gnt1    <= 1'b0;
          st          <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_atoi_ctl.sv
// Scoreboard bench for atoi_ctl with a byte memory and a behavioural atoi model.
module tb_atoi_ctl;

  localparam int unsigned DSZ    = 32;
  localparam int unsigned ASZ    = 17;
  localparam int unsigned MAXLEN = 4;
  localparam int unsigned MEMSZ  = 1 << ASZ;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  atoi_ctl_if #(.DSZ(DSZ), .ASZ(ASZ)) bus ();

  atoi_ctl #(.DSZ(DSZ), .ASZ(ASZ), .MAXLEN(MAXLEN)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Byte memory with one cycle read latency.
  logic [7:0] mem [0:MEMSZ-1];
  always @(posedge clk) bus.mdi <= mem[bus.ma];

  // Behavioural atoi: one char per ACC step, then an address advance and a memory wait.
  typedef enum logic [2:0] {M_IDLE, M_ACC, M_ADV, M_WAIT, M_END} mst_t;
  mst_t        m_st;
  logic [31:0] m_acc;
  logic        m_neg;
  logic        m_started;
  logic [3:0]  m_dv;
  logic        m_ok;

  assign bus.atoi_vo = m_neg ? (~m_acc + 32'd1) : m_acc;

  function automatic logic digit(input logic [7:0] c, input logic hx, output logic [3:0] v);
    v = 4'd0;
    if (c >= 8'h30 && c <= 8'h39) begin
      v = 4'(c - 8'h30);
      return 1'b1;
    end
    if (hx && c >= 8'h61 && c <= 8'h66) begin
      v = 4'(c - 8'h57);
      return 1'b1;
    end
    return 1'b0;
  endfunction

  always @(posedge clk) begin
    if (!bus.atoi_en) begin
      m_st         <= M_IDLE;
      bus.atoi_bsy <= 1'b0;
      bus.atoi_af  <= 1'b0;
      m_acc        <= 32'd0;
      m_neg        <= 1'b0;
      m_started    <= 1'b0;
    end else begin
      case (m_st)
        M_IDLE: begin
          bus.atoi_bsy <= 1'b1;
          m_st         <= M_ACC;
        end
        M_ACC: begin
          m_ok = digit(bus.atoi_ch, bus.atoi_hex, m_dv);
          if (bus.atoi_ch == 8'h2d && !m_started) begin
            m_neg       <= 1'b1;
            m_started   <= 1'b1;
            bus.atoi_af <= 1'b1;
            m_st        <= M_ADV;
          end else if (m_ok) begin
            m_acc       <= bus.atoi_hex ? {m_acc[27:0], m_dv} : (m_acc * 32'd10 + 32'(m_dv));
            m_started   <= 1'b1;
            bus.atoi_af <= 1'b1;
            m_st        <= M_ADV;
          end else begin
            bus.atoi_bsy <= 1'b0;
            m_st         <= M_END;
          end
        end
        M_ADV: begin
          bus.atoi_af <= 1'b0;
          m_st        <= M_WAIT;
        end
        M_WAIT: m_st <= M_ACC;
        default: m_st <= M_END;
      endcase
    end
  end

  // Scoreboard
  typedef struct {
    bit          port;
    logic [31:0] vo;
    bit          err;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;
  int   excl_viol = 0;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Monitor: pops one expectation per done pulse and watches grant exclusivity.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (bus.gnt0 && bus.gnt1) excl_viol++;
        if (bus.done0 || bus.done1) begin
          check("done_both", bus.done0 && bus.done1, 0);
          check("done_gnt", bus.done0 ? bus.gnt0 : bus.gnt1, 1);
          check("sb_pending", sb.size() != 0, 1);
          if (sb.size() != 0) begin
            e = sb.pop_front();
            check("done_port", bus.done1, e.port);
            check("vo", bus.vo, e.vo);
            check("err", bus.err, e.err);
          end
        end
      end
    end
  end

  function automatic logic sig(input int which);
    case (which)
      0: return bus.done0;
      1: return bus.done1;
      2: return bus.gnt0;
      3: return bus.gnt1;
      default: return bus.atoi_en;
    endcase
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  // Bounded wait for a DUT signal at negedge sampling points.
  task automatic wait_for(input string name, input int which, input int budget);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      seen = sig(which);
    end
    check(name, seen, 1);
  endtask

  task automatic load_str(input int unsigned addr, input string s);
    for (int i = 0; i < s.len(); i++) mem[addr + i] = s[i];
    mem[addr + s.len()] = 8'h00;
  endtask

  initial begin
    int   lat;
    logic en_seen;
    logic d0;
    logic seen;

    for (int i = 0; i < MEMSZ; i++) mem[i] = 8'h00;
    load_str(32'h100, "123");
    load_str(32'h200, "-ff");
    load_str(32'h400, "123456");
    load_str(32'h500, "99");

    rst = 1'b1;
    bus.req0 = 1'b0; bus.a0 = '0; bus.hex0 = 1'b0;
    bus.req1 = 1'b0; bus.a1 = '0; bus.hex1 = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    check("rst_gnt0", bus.gnt0, 0);
    check("rst_gnt1", bus.gnt1, 0);
    check("rst_done", {bus.done0, bus.done1}, 0);
    check("rst_err", bus.err, 0);
    check("rst_vo", bus.vo, 0);
    check("rst_ma", bus.ma, 0);
    check("rst_en", bus.atoi_en, 0);
    check("rst_hex", bus.atoi_hex, 0);

    // Both requesters from reset: decimal on port 0 first, hex negative on port 1 next.
    bus.a0 = 17'h100; bus.hex0 = 1'b0;
    bus.a1 = 17'h200; bus.hex1 = 1'b1;
    sb.push_back('{port: 1'b0, vo: 32'd123, err: 1'b0});
    sb.push_back('{port: 1'b1, vo: 32'hFFFF_FF01, err: 1'b0});
    bus.req0 = 1'b1; bus.req1 = 1'b1;
    wait_for("done0_dec", 0, 200);
    check("ma_dec", bus.ma, 17'h103);
    bus.req0 = 1'b0;
    tick();
    check("gnt0_after_fin", bus.gnt0, 0);
    check("en_after_fin0", bus.atoi_en, 0);
    wait_for("done1_hex", 1, 200);
    bus.req1 = 1'b0;
    tick();

    // Both again: port 0 (empty token) then port 1 (timeout).
    bus.a0 = 17'h300; bus.hex0 = 1'b0;
    bus.a1 = 17'h400; bus.hex1 = 1'b0;
    sb.push_back('{port: 1'b0, vo: 32'd0, err: 1'b1});
    sb.push_back('{port: 1'b1, vo: 32'd0, err: 1'b1});
    bus.req0 = 1'b1; bus.req1 = 1'b1;
    wait_for("gnt0_empty", 2, 20);
    lat = 1;
    en_seen = bus.atoi_en;
    while (!bus.done0 && lat < 20) begin
      tick();
      lat++;
      en_seen |= bus.atoi_en;
    end
    check("empty_latency", 64'(lat), 3);
    bus.req0 = 1'b0;
    tick();
    en_seen |= bus.atoi_en;
    check("empty_en", en_seen, 0);
    wait_for("done1_timeout", 1, 200);
    check("ma_timeout", bus.ma, 17'h404);
    bus.req1 = 1'b0;
    tick();
    check("en_after_timeout", bus.atoi_en, 0);

    // Re-establish vo = 123.
    bus.a0 = 17'h100; bus.hex0 = 1'b0;
    sb.push_back('{port: 1'b0, vo: 32'd123, err: 1'b0});
    bus.req0 = 1'b1;
    wait_for("done0_again", 0, 200);
    bus.req0 = 1'b0;
    tick();

    // Abort port 0 mid-RUN with port 1 waiting.
    bus.a0 = 17'h500;
    bus.req0 = 1'b1;
    wait_for("gnt0_abort", 2, 20);
    wait_for("en0_abort", 4, 20);
    repeat (3) tick();
    bus.a1 = 17'h200; bus.hex1 = 1'b1;
    bus.req1 = 1'b1;
    tick();
    bus.req0 = 1'b0;
    d0 = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      d0 |= bus.done0;
      if (bus.gnt1) begin
        seen = 1'b1;
        break;
      end
    end
    check("abort_gnt1", seen, 1);
    check("abort_no_done0", d0, 0);
    check("abort_vo_kept", bus.vo, 32'd123);
    check("abort_err_kept", bus.err, 0);

    // Asynchronous reset in the middle of port 1's RUN.
    wait_for("en1_run", 4, 20);
    repeat (4) tick();
    check("pre_rst_gnt1", bus.gnt1, 1);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_gnt1", bus.gnt1, 0);
    check("arst_en", bus.atoi_en, 0);
    check("arst_vo", bus.vo, 0);
    check("arst_ma", bus.ma, 0);
    check("arst_hex", bus.atoi_hex, 0);
    check("arst_err", bus.err, 0);
    check("arst_done1", bus.done1, 0);
    bus.req1 = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    repeat (3) tick();

    check("sb_empty", 64'(sb.size()), 0);
    check("gnt_excl", 64'(excl_viol), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
